// File: rtl/pipe_stage_skid_reg.sv
// Parametrised pipeline stage register with a one-entry skid buffer.
// Entries move on a valid/ready handshake. in_ready comes only from registered
// state, so no combinational path runs from out_ready to in_ready. A
// synchronous flush squashes everything held in the stage. A saturating
// counter records how many cycles the head entry was back-pressured.
module pipe_stage_skid_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  stat_clr,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                state, state_next;
  logic [CTRL_WIDTH-1:0] main_ctrl, main_ctrl_next;
  logic [DATA_WIDTH-1:0] main_data, main_data_next;
  logic [CTRL_WIDTH-1:0] skid_ctrl, skid_ctrl_next;
  logic [DATA_WIDTH-1:0] skid_data, skid_data_next;

  logic accept;
  logic drain;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // The main slot is cleared whenever it is vacated. The gating below also
  // keeps the outputs at zero while the stage is empty.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = out_valid ? main_data : '0;

  // Next-state and slot-update logic. Flush takes precedence over any handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first, so a path that
    // skips an assignment still produces a defined value and no latch is inferred.
    state_next     = state;
    main_ctrl_next = main_ctrl;
    main_data_next = main_data;
    skid_ctrl_next = skid_ctrl;
    skid_data_next = skid_data;

    if (flush) begin
      state_next     = EMPTY;
      main_ctrl_next = '0;
      main_data_next = '0;
      skid_ctrl_next = '0;
      skid_data_next = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
            state_next     = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end else if (accept) begin
            skid_ctrl_next = in_ctrl;
            skid_data_next = in_data;
            state_next     = TWO;
          end else if (drain) begin
            main_ctrl_next = '0;
            main_data_next = '0;
            state_next     = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_ctrl_next = skid_ctrl;
            main_data_next = skid_data;
            skid_ctrl_next = '0;
            skid_data_next = '0;
            state_next     = ONE;
          end
        end
        default: begin
          state_next     = EMPTY;
          main_ctrl_next = '0;
          main_data_next = '0;
          skid_ctrl_next = '0;
          skid_data_next = '0;
        end
      endcase
    end
  end

  // State and payload registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the clock edge, whatever the statement order.
    if (reset) begin
      // NOTE: the payload slots are reset on purpose. The outputs and the skid
      // slot must read as zero after reset, so these registers are not left free.
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_next;
      main_ctrl <= main_ctrl_next;
      main_data <= main_data_next;
      skid_ctrl <= skid_ctrl_next;
      skid_data <= skid_data_next;
    end
  end

  // Stall-cycle counter: saturating, cleared by stat_clr, and not affected by flush.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg. A queue-based reference model
// (capacity two, FIFO order) predicts every output after each clock edge.
// The bench runs directed scenarios first and then a randomized phase.
module tb_pipe_stage_skid_reg;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int CNT_SAT = (1 << NW) - 1;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready, stat_clr;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cycles;

  int tests_run  = 0;
  int tests_fail = 0;

  entry_t model_q[$];
  int     model_cnt = 0;

  pipe_stage_skid_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_data     (out_data),
    .stat_clr     (stat_clr),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Applies one cycle of stimulus, advances the model and the DUT, then compares.
  task automatic step(input logic rst, input logic fl, input logic iv, input logic [CW-1:0] ic,
                      input logic [DW-1:0] id, input logic ordy, input logic sclr);
    bit model_ready, acc, drn, stalled;
    entry_t e;
    reset = rst; flush = fl; in_valid = iv; in_ctrl = ic; in_data = id;
    out_ready = ordy; stat_clr = sclr;

    model_ready = (model_q.size() < 2);
    acc         = iv && model_ready;
    drn         = (model_q.size() > 0) && ordy;
    stalled     = (model_q.size() > 0) && !ordy;
    if (rst) begin
      model_q.delete();
      model_cnt = 0;
    end else begin
      if (sclr) model_cnt = 0;
      else if (stalled && model_cnt < CNT_SAT) model_cnt++;
      if (fl) begin
        model_q.delete();
      end else begin
        if (drn) void'(model_q.pop_front());
        if (acc) begin
          e.ctrl = ic; e.data = id;
          model_q.push_back(e);
        end
      end
    end

    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
    check("out_data", 64'(out_data), (model_q.size() > 0) ? 64'(model_q[0].data) : 64'd0);
    check("out_ctrl", 64'(out_ctrl), (model_q.size() > 0) ? 64'(model_q[0].ctrl) : 64'd0);
    check("stall_cycles", 64'(stall_cycles), 64'(model_cnt));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; stat_clr = 1'b0;

    // Reset with an in_valid entry present: nothing may be captured.
    step(1, 0, 1, 8'hA5, 32'hDEADBEEF, 0, 0);
    step(1, 0, 1, 8'hA5, 32'hDEADBEEF, 0, 0);
    step(0, 0, 0, 8'h00, 32'h0, 0, 0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Full-throughput stream: each entry appears one cycle after it is accepted.
    step(0, 0, 1, 8'h01, 32'h10, 1, 0);
    check("stream_a", 64'(out_data), 64'h10);
    step(0, 0, 1, 8'h02, 32'h20, 1, 0);
    check("stream_b", 64'(out_data), 64'h20);
    step(0, 0, 1, 8'h03, 32'h30, 1, 0);
    check("stream_c", 64'(out_data), 64'h30);
    check("stream_ready", 64'(in_ready), 64'd1);
    step(0, 0, 0, 8'h00, 32'h0, 1, 0);
    check("stream_empty", 64'(out_valid), 64'd0);

    // Back-pressure: first entry goes to main, second to skid, third is refused.
    step(0, 0, 1, 8'h11, 32'h10, 0, 0);
    step(0, 0, 1, 8'h12, 32'h20, 0, 0);
    check("bp_full", 64'(in_ready), 64'd0);
    step(0, 0, 1, 8'h13, 32'h30, 0, 0);
    check("bp_hold", 64'(out_data), 64'h10);
    check("bp_stall", 64'(stall_cycles), 64'd2);
    step(0, 0, 0, 8'h00, 32'h0, 1, 0);
    check("bp_drain1", 64'(out_data), 64'h20);
    step(0, 0, 0, 8'h00, 32'h0, 1, 0);
    check("bp_drain2", 64'(out_valid), 64'd0);

    // Flush in TWO with a concurrent input: everything is squashed.
    step(0, 0, 1, 8'h21, 32'h40, 0, 0);
    step(0, 0, 1, 8'h22, 32'h50, 0, 0);
    step(0, 1, 1, 8'h23, 32'h60, 0, 0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl", 64'(out_ctrl), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    step(0, 0, 0, 8'h00, 32'h0, 1, 0);
    check("flush_dropped", 64'(out_valid), 64'd0);

    // Saturation of the stall counter, followed by a clear.
    step(0, 0, 0, 8'h00, 32'h0, 1, 1);
    step(0, 0, 1, 8'h31, 32'h70, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 8'h00, 32'h0, 0, 0);
    check("sat_value", 64'(stall_cycles), 64'(CNT_SAT));
    step(0, 0, 0, 8'h00, 32'h0, 0, 1);
    check("sat_clear", 64'(stall_cycles), 64'd0);

    // Randomized traffic with occasional flush, reset and statistic clears.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           CW'($urandom),
           DW'($urandom),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised pipeline stage register, successor to the fixed-field EX/MEM latch.
- Carries a generic control vector and a generic data vector between stages using a valid/ready handshake.
- A one-entry skid buffer allows full throughput under back-pressure without a combinational ready path.
- Synchronous flush for branch/jump squash; saturating stall-cycle counter for performance analysis.

Parameters:
- DATA_WIDTH, 32, width of the data payload (results, PCs, store data).
- CTRL_WIDTH, 8, width of the control payload (memread, memwrite, regwrite, ...); forced to 0 whenever its slot is invalid.
- CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept this cycle.
- in_ctrl  input  CTRL_WIDTH  upstream control payload.
- in_data  input  DATA_WIDTH  upstream data payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head entry.
- out_ctrl  output  CTRL_WIDTH  head control payload, 0 when out_valid=0.
- out_data  output  DATA_WIDTH  head data payload, 0 when out_valid=0.
- stat_clr  input  1  synchronous clear of stall_cycles.
- stall_cycles  output  CNT_WIDTH  saturating count of back-pressured cycles.

Behaviour:
- Storage: main slot (drives out_*) and skid slot. States: EMPTY (none valid), ONE (main valid), TWO (main and skid valid).
- Reset (priority 1):
  - state EMPTY; out_valid=0, out_ctrl=0, out_data=0; skid contents 0; stall_cycles=0; in_ready=1.
  - in_valid is ignored while reset=1.
- Flush (priority 2):
  - next state EMPTY; main and skid ctrl/data cleared to 0.
  - A same-cycle in_valid entry is dropped, not captured.
  - stall_cycles is unaffected.
- in_ready = (state != TWO). It is a function of registered state only: no combinational path from out_ready or in_valid.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Transitions (no reset/flush):
  - EMPTY: accept -> main<=in, ONE; else stay.
  - ONE: accept&drain -> main<=in, ONE; accept&!drain -> skid<=in, TWO; !accept&drain -> main cleared to 0, EMPTY; else hold.
  - TWO: drain -> main<=skid, skid cleared, ONE; else hold. No accept is possible in TWO.
- Latency: an entry accepted in cycle N is visible on out_* in cycle N+1 if the stage was EMPTY, or was ONE and draining.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush/reset.
- Throughput: sustained 1 entry/cycle when out_ready=1.
- Payload is held stable while out_valid=1 and out_ready=0.
- stall_cycles:
  - +1 on each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_WIDTH-1.
  - stat_clr sets it to 0 and overrides an increment in the same cycle.
- Reset or flush mid-stall: in the next cycle out_valid=0 and in_ready=1.

Test Plan:
- Reset with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, out_data=0, out_ctrl=0, in_ready=1 one cycle after reset release; nothing captured.
- Stream A=0x10, B=0x20, C=0x30 with out_ready=1 -> out_data 0x10, 0x20, 0x30 on consecutive cycles, each one cycle after acceptance; in_ready stays 1.
- Stream with out_ready=0 -> first entry held in main, second in skid, in_ready=0; third entry is not accepted; stall_cycles increments each cycle. Raising out_ready then drains in order with no loss or duplication.
- In state TWO assert flush together with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the flush-cycle input is absent from the output.
- CNT_WIDTH=4, out_valid=1, out_ready=0 held for 20 cycles -> stall_cycles=15 (saturated); then stat_clr=1 -> 0 next cycle.
